// File: rtl/gate_chk_pkg.sv
// Shared types and golden truth table for the two-input gates self-check.
// Bit order of an 8-bit gate vector: [7]AND [6]OR [5]NOT [4]NAND [3]NOR [2]XOR [1]XNOR [0]BUFFER.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    FIN
  } state_t;

  localparam int AND_BIT    = 7;
  localparam int OR_BIT     = 6;
  localparam int NOT_BIT    = 5;
  localparam int NAND_BIT   = 4;
  localparam int NOR_BIT    = 3;
  localparam int XOR_BIT    = 2;
  localparam int XNOR_BIT   = 1;
  localparam int BUFFER_BIT = 0;

  // NOT and BUFFER both follow A only; B does not affect them.
  localparam logic [7:0] GOLD_00 = 8'h3A;
  localparam logic [7:0] GOLD_01 = 8'h74;
  localparam logic [7:0] GOLD_10 = 8'h55;
  localparam logic [7:0] GOLD_11 = 8'hC3;

  function automatic logic [7:0] golden(input logic a, input logic b);
    logic [7:0] g;
    case ({a, b})
      2'b00:   g = GOLD_00;
      2'b01:   g = GOLD_01;
      2'b10:   g = GOLD_10;
      default: g = GOLD_11;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational expected gates output for a given A/B pair.
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] expected
);

  assign expected = golden(a, b);

endmodule

// File: rtl/gate_truth_checker.sv
// Walks A/B through 00,01,10,11, lets the gates block settle, then compares its outputs
// against the golden table and reports pass, failing-vector count and a sticky per-gate mask.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [7:0] gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [7:0] fail_mask
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] vec, vec_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] err_nxt;
  logic [7:0] mask_nxt;
  logic       pass_nxt;
  logic [7:0] expected;
  logic [7:0] mism;

  gate_golden_model u_golden (
    .a        (a_out),
    .b        (b_out),
    .expected (expected)
  );

  // A/B come straight from the vector register, so they are glitch-free.
  assign a_out = vec[1];
  assign b_out = vec[0];
  assign mism  = gate_out ^ expected;
  assign busy  = (state != IDLE);
  assign done  = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      err_count <= '0;
      fail_mask <= '0;
      pass      <= 1'b0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      cnt       <= cnt_nxt;
      err_count <= err_nxt;
      fail_mask <= mask_nxt;
      pass      <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    err_nxt   = err_count;
    mask_nxt  = fail_mask;
    pass_nxt  = pass;
    case (state)
      IDLE: begin
        if (start) begin
          vec_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = '0;
          mask_nxt  = '0;
          pass_nxt  = 1'b0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == SETTLE_LAST) state_nxt = CHECK;
      end
      CHECK: begin
        mask_nxt = fail_mask | mism;
        // At most four vectors fail, so the 3-bit count never wraps.
        if (|mism) err_nxt = err_count + 3'd1;
        if (vec == 2'd3) begin
          state_nxt = FIN;
        end else begin
          vec_nxt   = vec + 2'd1;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      FIN: begin
        pass_nxt  = (err_count == 3'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (settle 2 and 1) against a timeline model of a run.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [7:0] mask0, mask1, go0, go1;
  logic [7:0] fault [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference gates block: plain boolean definitions.
  function automatic logic [7:0] gates_fn(input logic a, input logic b);
    return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b), a};
  endfunction

  assign go0 = gates_fn(a0, b0) ^ fault[{a0, b0}];
  assign go1 = gates_fn(a1, b1) ^ fault[{a1, b1}];

  gate_truth_checker #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a_out(a0), .b_out(b0), .gate_out(go0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_mask(mask0)
  );

  gate_truth_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a_out(a1), .b_out(b1), .gate_out(go1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1)
  );

  task automatic chk(input string name, input int inst, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%h expected=%h at %0t", name, inst, got, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // A run accepted at edge e0 holds vector k during edges e0+k*(S+1) .. e0+(k+1)*(S+1),
  // records vector k at edge e0+(k+1)*(S+1), shows done after edge e0+4*(S+1) and goes idle one edge later.
  int         s_cyc [2] = '{2, 1};
  bit         m_act [2];
  int         m_r [2];
  int         m_idle_vecs [2];
  logic [1:0] m_idle_vec [2];
  logic       m_pass [2];
  logic [7:0] m_snap [2][4];

  function automatic int m_nvec(input int i);
    int v;
    if (!m_act[i]) return m_idle_vecs[i];
    v = m_r[i] / (s_cyc[i] + 1);
    return (v > 4) ? 4 : v;
  endfunction

  function automatic logic [7:0] m_mask(input int i);
    logic [7:0] m = 8'h00;
    for (int j = 0; j < m_nvec(i); j++) m |= m_snap[i][j];
    return m;
  endfunction

  function automatic logic [7:0] m_err(input int i);
    logic [7:0] e = 8'h00;
    for (int j = 0; j < m_nvec(i); j++) if (m_snap[i][j] != 8'h00) e++;
    return e;
  endfunction

  function automatic logic [1:0] m_vec(input int i);
    int v;
    if (!m_act[i]) return m_idle_vec[i];
    v = m_r[i] / (s_cyc[i] + 1);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  task automatic model_step(input int i);
    if (rst) begin
      m_act[i] = 1'b0;
      m_idle_vecs[i] = 0;
      m_idle_vec[i] = 2'd0;
      m_pass[i] = 1'b0;
    end else if (m_act[i]) begin
      m_r[i]++;
      if (m_r[i] == 4 * (s_cyc[i] + 1) + 1) begin
        m_act[i] = 1'b0;
        m_idle_vecs[i] = 4;
        m_idle_vec[i] = 2'd3;
        m_pass[i] = (m_err(i) == 8'h00);
      end
    end else if (start) begin
      m_act[i] = 1'b1;
      m_r[i] = 0;
      m_pass[i] = 1'b0;
      for (int j = 0; j < 4; j++) m_snap[i][j] = fault[j];
    end
  endtask

  task automatic cmp_inst(input int i, input logic busy, input logic done, input logic a, input logic b,
                          input logic pass, input logic [2:0] err, input logic [7:0] mask);
    logic [1:0] v;
    v = m_vec(i);
    chk("busy", i, {7'd0, busy}, {7'd0, m_act[i]});
    chk("done", i, {7'd0, done}, {7'd0, m_act[i] && (m_r[i] == 4 * (s_cyc[i] + 1))});
    chk("a_out", i, {7'd0, a}, {7'd0, v[1]});
    chk("b_out", i, {7'd0, b}, {7'd0, v[0]});
    chk("pass", i, {7'd0, pass}, {7'd0, m_pass[i]});
    chk("err_count", i, {5'd0, err}, m_err(i));
    chk("fail_mask", i, mask, m_mask(i));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #2;
      cmp_inst(0, busy0, done0, a0, b0, pass0, err0, mask0);
      cmp_inst(1, busy1, done1, a1, b1, pass1, err1, mask1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (!busy0 && !busy1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle busy0=%0b busy1=%0b still set after %0d cycles", busy0, busy1, bound);
  endtask

  // Starts a run and returns cycles from the accepting edge to the done cycle for each instance.
  task automatic run_measure(input int repulse_at, output int l0, output int l1);
    l0 = -1;
    l1 = -1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #2;
      if (n == repulse_at) start = 1'b1;
      else start = 1'b0;
      if (done0 && l0 < 0) l0 = n - 1;
      if (done1 && l1 < 0) l1 = n - 1;
      if (l0 >= 0 && l1 >= 0 && !busy0 && !busy1) break;
    end
    start = 1'b0;
  endtask

  task automatic set_fault_xor0();
    for (int k = 0; k < 4; k++) fault[k] = gates_fn(k[1], k[0]) & 8'h04;
  endtask

  initial begin
    int l0, l1;
    logic [7:0] t;
    rst = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) fault[k] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Pin the reference gates against hand-derived truth table values.
    t = gates_fn(1'b0, 1'b0); chk("gold_00", 0, t, 8'h3A);
    t = gates_fn(1'b0, 1'b1); chk("gold_01", 0, t, 8'h74);
    t = gates_fn(1'b1, 1'b0); chk("gold_10", 0, t, 8'h55);
    t = gates_fn(1'b1, 1'b1); chk("gold_11", 0, t, 8'hC3);

    // Clean run.
    run_measure(0, l0, l1);
    chk("lat_clean", 0, 8'(l0), 8'd12);
    chk("lat_clean", 1, 8'(l1), 8'd8);
    wait_idle(40);
    chk("pass_clean", 0, {7'd0, pass0}, 8'd1);
    chk("pass_clean", 1, {7'd0, pass1}, 8'd1);
    chk("ab_final", 0, {6'd0, a0, b0}, 8'd3);

    // XOR stuck at 0: vectors 01 and 10 fail.
    set_fault_xor0();
    run_measure(0, l0, l1);
    wait_idle(40);
    chk("xor_err", 0, {5'd0, err0}, 8'd2);
    chk("xor_mask", 0, mask0, 8'h04);
    chk("xor_pass", 0, {7'd0, pass0}, 8'd0);

    // All outputs stuck at 1.
    for (int k = 0; k < 4; k++) fault[k] = ~gates_fn(k[1], k[0]);
    run_measure(0, l0, l1);
    wait_idle(40);
    chk("ff_err", 0, {5'd0, err0}, 8'd4);
    chk("ff_mask", 0, mask0, 8'hFF);
    chk("ff_err", 1, {5'd0, err1}, 8'd4);

    // Start re-pulsed while busy must not move done.
    set_fault_xor0();
    run_measure(4, l0, l1);
    chk("lat_repulse", 0, 8'(l0), 8'd12);
    wait_idle(40);

    // Start held high: back-to-back runs, results cleared at the second start.
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 40 && !done0; n++) @(posedge clk) #2;
    @(posedge clk) #2;
    chk("b2b_gap_busy", 0, {7'd0, busy0}, 8'd0);
    chk("b2b_gap_err", 0, {5'd0, err0}, 8'd2);
    @(posedge clk) #2;
    chk("b2b_restart_busy", 0, {7'd0, busy0}, 8'd1);
    chk("b2b_restart_err", 0, {5'd0, err0}, 8'd0);
    start = 1'b0;
    wait_idle(60);

    // Reset during the third vector of the settle-2 instance.
    for (int k = 0; k < 4; k++) fault[k] = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_vec", 0, {6'd0, a0, b0}, 8'd2);
    rst = 1'b1;
    @(posedge clk) #2;
    chk("rst_busy", 0, {7'd0, busy0}, 8'd0);
    chk("rst_ab", 0, {6'd0, a0, b0}, 8'd0);
    chk("rst_done", 0, {7'd0, done0}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    run_measure(0, l0, l1);
    chk("lat_after_rst", 0, 8'(l0), 8'd12);
    wait_idle(40);
    chk("pass_after_rst", 0, {7'd0, pass0}, 8'd1);

    // Randomized runs: random faults, gaps, start pulses and occasional reset.
    for (int it = 0; it < 60; it++) begin
      wait_idle(60);
      for (int k = 0; k < 4; k++) fault[k] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(0, 8)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_idle(60);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
